sdram_arbit_rr: RTL and testbench

SDRAM_ARBIT_RR -- requirements
Module: sdram_arbit_rr

---
 rtl/sdram_pkg.sv | 20 ++
 rtl/sdram_rr_pick.sv | 29 ++
 rtl/sdram_arbit_rr.sv | 175 +++++++++++++++++
 tb/tb_sdram_arbit_rr.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM round-robin arbiter: command encodings,
// arbiter states and default parameter values.
package sdram_pkg;

  localparam logic [3:0] CMD_NOP = 4'b0111;

  localparam int DEF_NCH       = 4;
  localparam int DEF_BANK_W    = 2;
  localparam int DEF_ADDR_W    = 13;
  localparam int DEF_DQ_W      = 16;
  localparam int DEF_MAX_GRANT = 1023;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    AR   = 2'd2,
    CH   = 2'd3
  } arb_state_e;

endpackage

// File: rtl/sdram_rr_pick.sv
// Cyclic priority search: returns the first requester at or after ptr,
// wrapping from NCH-1 back to 0.
module sdram_rr_pick
  import sdram_pkg::*;
#(
  parameter int NCH = DEF_NCH
) (
  input  logic [NCH-1:0]         req,
  input  logic [$clog2(NCH)-1:0] ptr,
  output logic                   valid,
  output logic [$clog2(NCH)-1:0] idx
);

  always_comb begin
    int c;
    c     = 0;
    valid = 1'b0;
    idx   = '0;
    for (int k = 0; k < NCH; k++) begin
      c = int'(ptr) + k;
      if (c >= NCH) c = c - NCH;
      if (!valid && req[c]) begin
        valid = 1'b1;
        idx   = $clog2(NCH)'(c);
      end
    end
  end

endmodule

// File: rtl/sdram_arbit_rr.sv
// SDRAM command arbiter: init sequencer until init_end, then refresh with
// absolute priority and round-robin channel grants guarded by a watchdog.
module sdram_arbit_rr
  import sdram_pkg::*;
#(
  parameter int NCH       = DEF_NCH,
  parameter int BANK_W    = DEF_BANK_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DQ_W      = DEF_DQ_W,
  parameter int MAX_GRANT = DEF_MAX_GRANT
) (
  input  logic                     arb_clk,
  input  logic                     arb_rst,
  input  logic                     init_end,
  input  logic [3:0]               init_cmd,
  input  logic [BANK_W-1:0]        init_bank,
  input  logic [ADDR_W-1:0]        init_addr,
  input  logic                     ar_req,
  input  logic                     ar_end,
  input  logic [3:0]               ar_cmd,
  input  logic [BANK_W-1:0]        ar_bank,
  input  logic [ADDR_W-1:0]        ar_addr,
  input  logic [NCH-1:0]           ch_req,
  input  logic [NCH-1:0]           ch_end,
  input  logic [4*NCH-1:0]         ch_cmd,
  input  logic [BANK_W*NCH-1:0]    ch_bank,
  input  logic [ADDR_W*NCH-1:0]    ch_addr,
  input  logic [NCH-1:0]           ch_dq_en,
  input  logic [DQ_W*NCH-1:0]      ch_dq,
  output logic                     ar_en,
  output logic [NCH-1:0]           ch_en,
  output logic [$clog2(NCH)-1:0]   grant_idx,
  output logic                     sdram_cke,
  output logic                     sdram_cs_n,
  output logic                     sdram_ras_n,
  output logic                     sdram_cas_n,
  output logic                     sdram_we_n,
  output logic [BANK_W-1:0]        sdram_bank,
  output logic [ADDR_W-1:0]        sdram_addr,
  output logic [DQ_W-1:0]          sdram_dq_out,
  output logic                     sdram_dq_oe,
  output logic                     wdog_err
);

  localparam int IDX_W = $clog2(NCH);
  localparam int CNT_W = $clog2(MAX_GRANT + 1);

  arb_state_e        state_q;
  logic [IDX_W-1:0]  rrPtr_q, grantIdx_q;
  logic [NCH-1:0]    chEn_q;
  logic              arEn_q, wdogErr_q, dqOe_q;
  logic [CNT_W-1:0]  wdCnt_q;
  logic [3:0]        cmd_q;
  logic [BANK_W-1:0] bank_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DQ_W-1:0]   dqOut_q;

  logic              pickValid;
  logic [IDX_W-1:0]  pickIdx;
  logic [3:0]        selCmd;
  logic [BANK_W-1:0] selBank;
  logic [ADDR_W-1:0] selAddr;
  logic [DQ_W-1:0]   selDq;
  logic              selDqEn, selEnd, wdHit;

  sdram_rr_pick #(.NCH(NCH)) u_pick (
    .req   (ch_req),
    .ptr   (rrPtr_q),
    .valid (pickValid),
    .idx   (pickIdx)
  );

  // Fields of the currently granted channel
  always_comb begin
    int gi;
    gi      = int'(grantIdx_q);
    selCmd  = ch_cmd[gi*4 +: 4];
    selBank = ch_bank[gi*BANK_W +: BANK_W];
    selAddr = ch_addr[gi*ADDR_W +: ADDR_W];
    selDq   = ch_dq[gi*DQ_W +: DQ_W];
    selDqEn = ch_dq_en[gi];
    selEnd  = ch_end[gi];
  end

  assign wdHit = (wdCnt_q == CNT_W'(MAX_GRANT - 1));

  always_ff @(posedge arb_clk) begin
    if (arb_rst) begin
      state_q    <= IDLE;
      rrPtr_q    <= '0;
      grantIdx_q <= '0;
      chEn_q     <= '0;
      arEn_q     <= 1'b0;
      wdCnt_q    <= '0;
      wdogErr_q  <= 1'b0;
      cmd_q      <= CMD_NOP;
      bank_q     <= '1;
      addr_q     <= '1;
      dqOut_q    <= '0;
      dqOe_q     <= 1'b0;
    end else begin
      // NOP is the fallback; each state overrides with its own source
      wdogErr_q <= 1'b0;
      cmd_q     <= CMD_NOP;
      bank_q    <= '1;
      addr_q    <= '1;
      dqOut_q   <= '0;
      dqOe_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          cmd_q  <= init_cmd;
          bank_q <= init_bank;
          addr_q <= init_addr;
          if (init_end) state_q <= ARB;
        end
        ARB: begin
          wdCnt_q <= '0;
          if (ar_req) begin
            state_q <= AR;
            arEn_q  <= 1'b1;
          end else if (pickValid) begin
            state_q    <= CH;
            chEn_q     <= NCH'(1) << pickIdx;
            grantIdx_q <= pickIdx;
            rrPtr_q    <= (pickIdx == IDX_W'(NCH - 1)) ? '0 : pickIdx + IDX_W'(1);
          end
        end
        AR: begin
          if (ar_end || !wdHit) begin
            cmd_q  <= ar_cmd;
            bank_q <= ar_bank;
            addr_q <= ar_addr;
          end
          if (ar_end || wdHit) begin
            state_q   <= ARB;
            arEn_q    <= 1'b0;
            wdogErr_q <= !ar_end;
          end else begin
            wdCnt_q <= wdCnt_q + CNT_W'(1);
          end
        end
        CH: begin
          if (selEnd || !wdHit) begin
            cmd_q   <= selCmd;
            bank_q  <= selBank;
            addr_q  <= selAddr;
            dqOut_q <= selDq;
            dqOe_q  <= selDqEn;
          end
          if (selEnd || wdHit) begin
            state_q    <= ARB;
            chEn_q     <= '0;
            grantIdx_q <= '0;
            wdogErr_q  <= !selEnd;
          end else begin
            wdCnt_q <= wdCnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ar_en        = arEn_q;
  assign ch_en        = chEn_q;
  assign grant_idx    = grantIdx_q;
  assign wdog_err     = wdogErr_q;
  assign sdram_cke    = 1'b1;
  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_q;
  assign sdram_bank   = bank_q;
  assign sdram_addr   = addr_q;
  assign sdram_dq_out = dqOut_q;
  assign sdram_dq_oe  = dqOe_q;

endmodule

// File: tb/tb_sdram_arbit_rr.sv
// Bench for sdram_arbit_rr: directed scenarios plus a random phase, every
// cycle compared against a grant-ownership model of the arbiter.
module tb_sdram_arbit_rr;

  localparam int NCH    = 4;
  localparam int BANK_W = 2;
  localparam int ADDR_W = 13;
  localparam int DQ_W   = 16;
  localparam int MAXG   = 8;
  localparam int NONE   = -1;
  localparam int REFR   = -2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  init_end = 1'b0;
  logic [3:0]            init_cmd = '0;
  logic [BANK_W-1:0]     init_bank = '0;
  logic [ADDR_W-1:0]     init_addr = '0;
  logic                  ar_req = 1'b0, ar_end = 1'b0;
  logic [3:0]            ar_cmd = '0;
  logic [BANK_W-1:0]     ar_bank = '0;
  logic [ADDR_W-1:0]     ar_addr = '0;
  logic [NCH-1:0]        ch_req = '0, ch_end = '0, ch_dq_en = '0;
  logic [4*NCH-1:0]      ch_cmd = '0;
  logic [BANK_W*NCH-1:0] ch_bank = '0;
  logic [ADDR_W*NCH-1:0] ch_addr = '0;
  logic [DQ_W*NCH-1:0]   ch_dq = '0;

  logic                  ar_en, wdog_err, cke, cs_n, ras_n, cas_n, we_n, dq_oe;
  logic [NCH-1:0]        ch_en;
  logic [1:0]            grant_idx;
  logic [BANK_W-1:0]     sd_bank;
  logic [ADDR_W-1:0]     sd_addr;
  logic [DQ_W-1:0]       dq_out;

  int asserts  = 0;
  int failures = 0;
  bit forceDqEn = 1'b0;

  // Model: who owns the bus, plus the outputs expected after the next edge
  bit              mInit;
  int              mOwner, mPtr, mAge;
  logic [3:0]      eCmd;
  logic [BANK_W-1:0] eBank;
  logic [ADDR_W-1:0] eAddr;
  logic [DQ_W-1:0] eDq;
  logic            eOe, eWd;

  sdram_arbit_rr #(.NCH(NCH), .BANK_W(BANK_W), .ADDR_W(ADDR_W), .DQ_W(DQ_W),
                   .MAX_GRANT(MAXG)) dut (
    .arb_clk(clk), .arb_rst(rst),
    .init_end(init_end), .init_cmd(init_cmd), .init_bank(init_bank), .init_addr(init_addr),
    .ar_req(ar_req), .ar_end(ar_end), .ar_cmd(ar_cmd), .ar_bank(ar_bank), .ar_addr(ar_addr),
    .ch_req(ch_req), .ch_end(ch_end), .ch_cmd(ch_cmd), .ch_bank(ch_bank), .ch_addr(ch_addr),
    .ch_dq_en(ch_dq_en), .ch_dq(ch_dq),
    .ar_en(ar_en), .ch_en(ch_en), .grant_idx(grant_idx),
    .sdram_cke(cke), .sdram_cs_n(cs_n), .sdram_ras_n(ras_n), .sdram_cas_n(cas_n),
    .sdram_we_n(we_n), .sdram_bank(sd_bank), .sdram_addr(sd_addr),
    .sdram_dq_out(dq_out), .sdram_dq_oe(dq_oe), .wdog_err(wdog_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    asserts++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic setNop();
    eCmd = 4'b0111; eBank = '1; eAddr = '1; eDq = '0; eOe = 1'b0;
  endtask

  task automatic modelUpdate();
    bit done;
    int c;
    if (rst) begin
      mInit = 0; mOwner = NONE; mPtr = 0; mAge = 0; eWd = 0;
      setNop();
      return;
    end
    eWd = 0;
    setNop();
    if (!mInit) begin
      eCmd = init_cmd; eBank = init_bank; eAddr = init_addr;
      if (init_end) mInit = 1;
    end else if (mOwner == NONE) begin
      mAge = 0;
      if (ar_req) mOwner = REFR;
      else begin
        for (int k = 0; k < NCH; k++) begin
          c = (mPtr + k) % NCH;
          if (mOwner == NONE && ch_req[c]) begin
            mOwner = c;
            mPtr   = (c + 1) % NCH;
          end
        end
      end
    end else begin
      mAge++;
      done = (mOwner == REFR) ? ar_end : ch_end[mOwner];
      if (!done && mAge == MAXG) begin
        eWd = 1;
      end else if (mOwner == REFR) begin
        eCmd = ar_cmd; eBank = ar_bank; eAddr = ar_addr;
      end else begin
        eCmd  = ch_cmd[mOwner*4 +: 4];
        eBank = ch_bank[mOwner*BANK_W +: BANK_W];
        eAddr = ch_addr[mOwner*ADDR_W +: ADDR_W];
        eDq   = ch_dq[mOwner*DQ_W +: DQ_W];
        eOe   = ch_dq_en[mOwner];
      end
      if (done || mAge == MAXG) mOwner = NONE;
    end
  endtask

  task automatic applyStimulus();
    init_cmd = 4'($urandom); init_bank = BANK_W'($urandom); init_addr = ADDR_W'($urandom);
    ar_cmd = 4'($urandom); ar_bank = BANK_W'($urandom); ar_addr = ADDR_W'($urandom);
    ch_cmd = (4*NCH)'($urandom); ch_bank = (BANK_W*NCH)'($urandom);
    ch_addr = {ADDR_W'($urandom), ADDR_W'($urandom), ADDR_W'($urandom), ADDR_W'($urandom)};
    ch_dq = {$urandom, $urandom};
    ch_dq_en = forceDqEn ? '1 : NCH'($urandom);
  endtask

  task automatic tick();
    logic [NCH-1:0] expEn;
    @(posedge clk);
    modelUpdate();
    @(negedge clk);
    expEn = (mOwner >= 0) ? NCH'(1) << mOwner : '0;
    checkOutput("arEn", 32'(ar_en), 32'(mOwner == REFR));
    checkOutput("chEn", 32'(ch_en), 32'(expEn));
    checkOutput("grantIdx", 32'(grant_idx), (mOwner >= 0) ? 32'(mOwner) : 32'd0);
    checkOutput("cmd", 32'({cs_n, ras_n, cas_n, we_n}), 32'(eCmd));
    checkOutput("bank", 32'(sd_bank), 32'(eBank));
    checkOutput("addr", 32'(sd_addr), 32'(eAddr));
    checkOutput("dqOut", 32'(dq_out), 32'(eDq));
    checkOutput("dqOe", 32'(dq_oe), 32'(eOe));
    checkOutput("wdog", 32'(wdog_err), 32'(eWd));
    checkOutput("cke", 32'(cke), 32'd1);
    applyStimulus();
  endtask

  task automatic waitGrant(input string tag, input logic [NCH-1:0] mask);
    int budget = 20;
    while ((ch_en & mask) == '0 && budget > 0) begin
      tick();
      budget--;
    end
    checkOutput(tag, 32'((ch_en & mask) != '0), 32'd1);
  endtask

  initial begin
    int expOrder[5] = '{0, 1, 2, 3, 0};
    int chCycles, wdPulses;

    // Reset
    applyStimulus();
    rst = 1'b1;
    tick(); tick();
    checkOutput("rstCmd", 32'({cs_n, ras_n, cas_n, we_n}), 32'h7);
    checkOutput("rstGrant", 32'({ar_en, ch_en}), 32'd0);

    // IDLE follows init fields with one cycle of latency
    rst = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    init_end = 1'b1;
    tick();
    init_end = 1'b0;
    tick();
    checkOutput("arbNop", 32'({cs_n, ras_n, cas_n, we_n}), 32'h7);

    // Four requesters held: grants rotate 0,1,2,3,0; stray end bits ignored
    ch_req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      waitGrant("rrGrant", 4'b1111);
      checkOutput("rrOrder", 32'(grant_idx), 32'(expOrder[n]));
      ch_end = NCH'(1) << ((mOwner + 1) % NCH);
      ar_end = 1'b1;
      tick();
      ch_end = '0; ar_end = 1'b0;
      tick();
      ch_end = NCH'(1) << mOwner;
      if (n == 4) ch_req = '0;
      tick();
      ch_end = '0;
    end

    // Refresh beats a simultaneous channel request
    ar_req = 1'b1; ch_req = 4'b0010;
    tick();
    checkOutput("arFirst", 32'({ar_en, ch_en}), 32'b10000);
    ar_req = 1'b0;
    tick(); tick();
    ar_end = 1'b1;
    tick();
    ar_end = 1'b0;
    checkOutput("arDone", 32'({ar_en, ch_en}), 32'd0);
    tick();
    checkOutput("ch1After", 32'(ch_en), 32'b0010);
    ch_end = 4'b0010; ch_req = '0;
    tick();
    ch_end = '0;

    // No preemption of channel 2 by refresh
    ch_req = 4'b0100;
    waitGrant("ch2Grant", 4'b0100);
    ch_req = '0; ar_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("noPreempt", 32'({ar_en, ch_en}), 32'b00100);
    end
    ch_end = 4'b0100;
    tick();
    ch_end = '0;
    checkOutput("viaArb", 32'({ar_en, ch_en}), 32'd0);
    tick();
    checkOutput("arAfterCh", 32'(ar_en), 32'd1);
    ar_req = 1'b0; ar_end = 1'b1;
    tick();
    ar_end = 1'b0;

    // Watchdog: channel 3 never ends
    ch_req = 4'b1000;
    waitGrant("wdGrant", 4'b1000);
    ch_req = '0;
    chCycles = 1; wdPulses = 0;
    for (int i = 0; i < 13; i++) begin
      tick();
      if (ch_en[3]) chCycles++;
      if (wdog_err) begin
        wdPulses++;
        checkOutput("wdNop", 32'({cs_n, ras_n, cas_n, we_n, ch_en}), 32'h70);
      end
    end
    checkOutput("wdCycles", 32'(chCycles), 32'(MAXG));
    checkOutput("wdPulses", 32'(wdPulses), 32'd1);

    // Reset in the middle of a write grant
    forceDqEn = 1'b1;
    ch_req = 4'b0001;
    waitGrant("rstGrant0", 4'b0001);
    tick();
    checkOutput("oeBefore", 32'(dq_oe), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0; ch_req = '0; forceDqEn = 1'b0;
    checkOutput("rstAbort", 32'({ar_en, ch_en, grant_idx, dq_oe}), 32'd0);
    for (int i = 0; i < 3; i++) tick();

    // Random traffic against the model
    for (int i = 0; i < 800; i++) begin
      rst      = ($urandom_range(0, 149) == 0);
      init_end = ($urandom_range(0, 7) == 0);
      ar_req   = ($urandom_range(0, 5) == 0);
      ar_end   = ($urandom_range(0, 3) == 0);
      ch_req   = NCH'($urandom);
      ch_end   = NCH'($urandom) & NCH'($urandom);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
